// File: rtl/sk6805_pkg.sv
// rtl/sk6805_pkg.sv - shared SK6805 timing constants and receiver state encoding
package sk6805_pkg;

    // 50 MHz clock: one count is 20 ns
    localparam int T_MIN_HIGH   = 5;     // 100 ns, shorter high pulses are glitches
    localparam int T_BIT_THRESH = 28;    // 560 ns, high at least this long is a '1'
    localparam int T_MAX_HIGH   = 60;    // 1.2 us, longer high is a protocol error
    localparam int T_RESET_CLKS = 4000;  // 80 us low latches the frame
    localparam int T_BIT_PERIOD = 63;    // transmit bit period, 1.25 us rounded up

    typedef enum logic [1:0] {
        ST_WAIT_RST = 2'd0,
        ST_IDLE     = 2'd1,
        ST_HIGH     = 2'd2,
        ST_LOW      = 2'd3
    } rx_state_t;

endpackage

// File: rtl/sk6805_rx_if.sv
// rtl/sk6805_rx_if.sv - readback and status bundle of the SK6805 receiver
interface sk6805_rx_if #(
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] i_addr;
    logic [7:0]        o_data;
    logic              o_valid;
    logic              o_frame;
    logic              o_err;

    modport master (output i_addr, input o_data, input o_valid, input o_frame, input o_err);
    modport slave  (input i_addr, output o_data, output o_valid, output o_frame, output o_err);
endinterface

// File: rtl/sk6805_rx_pulse_meas.sv
// rtl/sk6805_rx_pulse_meas.sv - input synchronizer, edge detect and level-run counter
module sk6805_rx_pulse_meas
    import sk6805_pkg::*;
#(
    parameter int CNT_W      = 12,
    parameter int RESET_CLKS = T_RESET_CLKS
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_din,
    output logic             o_rise,
    output logic             o_fall,
    output logic             o_din_dly,
    output logic [CNT_W-1:0] o_width,
    output logic             o_low_timeout
);

    logic             meta_q, meta_d;
    logic             sync_q, sync_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] run_q, run_d;

    // run_q holds how many clocks the previous synchronized level lasted, so on a
    // falling edge it is exactly the width of the high pulse that just ended
    always_comb begin
        meta_d = i_din;
        sync_d = meta_q;
        prev_d = sync_q;
        if (sync_q != prev_q) begin
            run_d = CNT_W'(1);
        end else if (run_q == '1) begin
            run_d = run_q;
        end else begin
            run_d = run_q + CNT_W'(1);
        end
    end

    // synchronizer, edge history and saturating run counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            run_q  <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
            run_q  <= run_d;
        end
    end

    assign o_rise        = sync_q & ~prev_q;
    assign o_fall        = ~sync_q & prev_q;
    assign o_width       = run_q;
    assign o_din_dly     = prev_q;
    assign o_low_timeout = ~sync_q && (run_d == CNT_W'(RESET_CLKS));

endmodule

// File: rtl/sk6805_rx.sv
// rtl/sk6805_rx.sv - SK6805/WS2812 single-wire receiver emulating one chain element
module sk6805_rx
    import sk6805_pkg::*;
#(
    parameter int COUNT      = 2,
    parameter int COLORS     = COUNT * 3,
    parameter int ADDR_W     = 3,
    parameter int CNT_W      = 12,
    parameter int MIN_HIGH   = T_MIN_HIGH,
    parameter int BIT_THRESH = T_BIT_THRESH,
    parameter int MAX_HIGH   = T_MAX_HIGH,
    parameter int RESET_CLKS = T_RESET_CLKS
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_din,
    output logic        o_dout,
    sk6805_rx_if.slave  bus
);

    localparam int BC_W = $clog2(COLORS + 1);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(COLORS);

    logic             rise, fall, din_dly, low_timeout;
    logic [CNT_W-1:0] width;

    rx_state_t        state_q, state_d;
    logic [6:0]       shift_q, shift_d;      // seven earlier bits; the eighth goes straight to staging
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [BC_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]       staging_q [COLORS];
    logic [7:0]       staging_d [COLORS];
    logic [7:0]       latched_q [COLORS];
    logic [7:0]       latched_d [COLORS];
    logic             valid_q, valid_d;
    logic             frame_q, frame_d;
    logic             err_q, err_d;
    logic             dout_q, dout_d;
    logic             bit_val;
    logic [7:0]       new_byte;

    sk6805_rx_pulse_meas #(
        .CNT_W      (CNT_W),
        .RESET_CLKS (RESET_CLKS)
    ) u_meas (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_din         (i_din),
        .o_rise        (rise),
        .o_fall        (fall),
        .o_din_dly     (din_dly),
        .o_width       (width),
        .o_low_timeout (low_timeout)
    );

    // decode FSM, bit capture into staging and frame latch into the read buffer
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        staging_d  = staging_q;
        latched_d  = latched_q;
        valid_d    = valid_q;
        frame_d    = 1'b0;
        err_d      = 1'b0;
        bit_val    = (width >= CNT_W'(BIT_THRESH));
        new_byte   = {shift_q, bit_val};
        // forward only once our own bytes are full; din_dly keeps the pulse width intact
        dout_d     = (byte_cnt_q == BC_FULL) && (state_q == ST_HIGH || state_q == ST_LOW)
                     ? din_dly : 1'b0;

        unique case (state_q)
            ST_WAIT_RST: begin
                // a frame already on the wire is ignored until a full reset gap
                if (low_timeout) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (rise) state_d = ST_HIGH;
            end
            ST_HIGH: begin
                if (fall) begin
                    if (width < CNT_W'(MIN_HIGH)) begin
                        err_d   = 1'b1;
                        state_d = ST_LOW;
                    end else if (width > CNT_W'(MAX_HIGH)) begin
                        err_d      = 1'b1;
                        state_d    = ST_WAIT_RST;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                    end else begin
                        state_d = ST_LOW;
                        if (byte_cnt_q != BC_FULL) begin
                            shift_d   = new_byte[6:0];
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                for (int i = 0; i < COLORS; i++) begin
                                    if (byte_cnt_q == BC_W'(i)) staging_d[i] = new_byte;
                                end
                                byte_cnt_d = byte_cnt_q + BC_W'(1);
                            end
                        end
                    end
                end
            end
            ST_LOW: begin
                if (rise) begin
                    state_d = ST_HIGH;
                end else if (low_timeout) begin
                    state_d = ST_IDLE;
                    if (byte_cnt_q == BC_FULL && bit_cnt_q == 3'd0) begin
                        latched_d = staging_q;
                        frame_d   = 1'b1;
                        valid_d   = 1'b1;
                    end else if (byte_cnt_q != '0 || bit_cnt_q != 3'd0) begin
                        err_d = 1'b1;
                    end
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                end
            end
            default: state_d = ST_WAIT_RST;
        endcase
    end

    // state and data registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_WAIT_RST;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            staging_q  <= '{default: '0};
            latched_q  <= '{default: '0};
            valid_q    <= 1'b0;
            frame_q    <= 1'b0;
            err_q      <= 1'b0;
            dout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            staging_q  <= staging_d;
            latched_q  <= latched_d;
            valid_q    <= valid_d;
            frame_q    <= frame_d;
            err_q      <= err_d;
            dout_q     <= dout_d;
        end
    end

    // byte readback from the latched buffer; out-of-range addresses read 0
    always_comb begin
        bus.o_data = '0;
        for (int i = 0; i < COLORS; i++) begin
            if (bus.i_addr == ADDR_W'(i)) bus.o_data = latched_q[i];
        end
    end

    assign bus.o_valid = valid_q;
    assign bus.o_frame = frame_q;
    assign bus.o_err   = err_q;
    assign o_dout      = dout_q;

endmodule

// File: tb/tb_sk6805_rx.sv
// tb/tb_sk6805_rx.sv - self-checking bench for the SK6805 receiver
module tb_sk6805_rx;

    localparam int COLORS     = 6;
    localparam int PASS_EDGES = 4;   // rising edges from the first one seeing new i_din to o_dout change

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic din   = 1'b0;
    logic dout;

    sk6805_rx_if #(.ADDR_W(3)) bus ();

    sk6805_rx #(.COUNT(2), .ADDR_W(3)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_din   (din),
        .o_dout  (dout),
        .bus     (bus)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int frame_cnt = 0;
    int err_cnt = 0;
    logic din_prev_m = 1'b0;
    logic dout_prev_m = 1'b0;
    int din_start = 0;
    int dout_start = 0;
    int din_st[$];
    int din_w[$];
    int dout_st[$];
    int dout_w[$];
    logic [7:0] model_latched [COLORS];
    logic model_valid = 1'b0;

    // monitor: pulse counts on status outputs and pulse timing on i_din / o_dout
    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.o_frame === 1'b1) frame_cnt++;
        if (bus.o_err === 1'b1) err_cnt++;
        if (din && !din_prev_m) din_start = cyc;
        if (!din && din_prev_m) begin
            din_st.push_back(din_start);
            din_w.push_back(cyc - din_start);
        end
        if (dout === 1'b1 && dout_prev_m !== 1'b1) dout_start = cyc;
        if (dout !== 1'b1 && dout_prev_m === 1'b1) begin
            dout_st.push_back(dout_start);
            dout_w.push_back(cyc - dout_start);
        end
        din_prev_m = din;
        dout_prev_m = dout;
    end

    task automatic send_level(input logic v, input int n);
        din = v;
        repeat (n) @(negedge clk);
    endtask

    // mode 0: nominal timing, 1: random legal timing, 2: boundary widths
    task automatic send_bit(input logic b, input int mode, input int idx);
        int hi, lo;
        case (mode)
            0: begin hi = b ? 40 : 15; lo = b ? 22 : 47; end
            1: begin
                hi = b ? int'($urandom_range(58, 30)) : int'($urandom_range(26, 6));
                lo = int'($urandom_range(30, 8));
            end
            default: begin
                hi = b ? ((idx % 2) ? 60 : 28) : ((idx % 2) ? 5 : 27);
                lo = 20;
            end
        endcase
        send_level(1'b1, hi);
        send_level(1'b0, lo);
    endtask

    task automatic send_byte(input logic [7:0] v, input int mode);
        for (int i = 7; i >= 0; i--) send_bit(v[i], mode, i);
    endtask

    task automatic send_frame(input logic [7:0] q [$], input int mode);
        foreach (q[i]) send_byte(q[i], mode);
    endtask

    // a frame of at least COLORS bytes latches its first COLORS bytes
    task automatic model_frame(input logic [7:0] q [$]);
        if (q.size() >= COLORS) begin
            for (int i = 0; i < COLORS; i++) model_latched[i] = q[i];
            model_valid = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        rst_n = 1'b0;
        din = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.o_valid !== 1'b0) $display("FAIL reset valid: got %b expected 0", bus.o_valid); else passes++;
        checks++; if (bus.o_frame !== 1'b0) $display("FAIL reset frame: got %b expected 0", bus.o_frame); else passes++;
        checks++; if (bus.o_err !== 1'b0) $display("FAIL reset err: got %b expected 0", bus.o_err); else passes++;
        checks++; if (dout !== 1'b0) $display("FAIL reset dout: got %b expected 0", dout); else passes++;
        for (int a = 0; a < 8; a++) begin
            bus.i_addr = 3'(a);
            #1;
            exp = 8'h00;
            checks++;
            if (bus.o_data !== exp) $display("FAIL reset data[%0d]: got %h expected %h", a, bus.o_data, exp);
            else passes++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_level(1'b0, 4010);
        checks++; if (frame_cnt !== 0 || err_cnt !== 0) $display("FAIL idle pulses: got frame=%0d err=%0d expected 0/0", frame_cnt, err_cnt); else passes++;
    endtask

    task automatic test_fixed_frame();
        logic [7:0] q [$];
        logic [7:0] exp;
        int f0, e0;
        q = '{8'hA5, 8'h0F, 8'hFF, 8'h00, 8'h81, 8'h3C};
        f0 = frame_cnt; e0 = err_cnt;
        send_frame(q, 0);
        send_level(1'b0, 4010);
        model_frame(q);
        checks++; if (frame_cnt - f0 !== 1) $display("FAIL fixed frame pulses: got %0d expected 1", frame_cnt - f0); else passes++;
        checks++; if (err_cnt - e0 !== 0) $display("FAIL fixed err pulses: got %0d expected 0", err_cnt - e0); else passes++;
        checks++; if (bus.o_valid !== model_valid) $display("FAIL fixed valid: got %b expected %b", bus.o_valid, model_valid); else passes++;
        for (int a = 0; a < 8; a++) begin
            bus.i_addr = 3'(a);
            #1;
            exp = (a < COLORS) ? model_latched[a] : 8'h00;
            checks++;
            if (bus.o_data !== exp) $display("FAIL fixed data[%0d]: got %h expected %h", a, bus.o_data, exp);
            else passes++;
        end
        @(negedge clk);
    endtask

    task automatic test_random_frames();
        logic [7:0] q [$];
        logic [7:0] exp;
        int f0, e0;
        for (int n = 0; n < 2; n++) begin
            q.delete();
            for (int i = 0; i < COLORS; i++) q.push_back(8'($urandom));
            f0 = frame_cnt; e0 = err_cnt;
            send_frame(q, 1);
            send_level(1'b0, 4010);
            model_frame(q);
            checks++; if (frame_cnt - f0 !== 1 || err_cnt - e0 !== 0) $display("FAIL random pulses: got frame=%0d err=%0d expected 1/0", frame_cnt - f0, err_cnt - e0); else passes++;
            for (int a = 0; a < COLORS; a++) begin
                bus.i_addr = 3'(a);
                #1;
                exp = model_latched[a];
                checks++;
                if (bus.o_data !== exp) $display("FAIL random data[%0d]: got %h expected %h", a, bus.o_data, exp);
                else passes++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_passthrough();
        logic [7:0] q [$];
        logic [7:0] exp;
        int f0, base;
        for (int i = 0; i < COLORS; i++) q.push_back(8'($urandom));
        q.push_back(8'h12); q.push_back(8'h34); q.push_back(8'h56);
        din_st.delete(); din_w.delete(); dout_st.delete(); dout_w.delete();
        f0 = frame_cnt;
        send_frame(q, 1);
        send_level(1'b0, 4010);
        model_frame(q);
        checks++; if (frame_cnt - f0 !== 1) $display("FAIL pass frame pulses: got %0d expected 1", frame_cnt - f0); else passes++;
        checks++; if (dout_st.size() !== 24) $display("FAIL pass pulse count: got %0d expected 24", dout_st.size()); else passes++;
        checks++; if (dout !== 1'b0) $display("FAIL pass dout idle: got %b expected 0", dout); else passes++;
        if (dout_st.size() == 24 && din_st.size() >= 24) begin
            base = din_st.size() - 24;
            for (int k = 0; k < 24; k++) begin
                checks++;
                if (dout_w[k] !== din_w[base + k])
                    $display("FAIL pass width[%0d]: got %0d expected %0d", k, dout_w[k], din_w[base + k]);
                else passes++;
                checks++;
                if (dout_st[k] - din_st[base + k] !== PASS_EDGES - 1)
                    $display("FAIL pass delay[%0d]: got %0d expected %0d", k, dout_st[k] - din_st[base + k] + 1, PASS_EDGES);
                else passes++;
            end
        end
        for (int a = 0; a < 8; a++) begin
            bus.i_addr = 3'(a);
            #1;
            exp = (a < COLORS) ? model_latched[a] : 8'h00;
            checks++;
            if (bus.o_data !== exp) $display("FAIL pass data[%0d]: got %h expected %h", a, bus.o_data, exp);
            else passes++;
        end
        @(negedge clk);
    endtask

    task automatic test_boundary();
        logic [7:0] qa [$];
        logic [7:0] qb [$];
        logic [7:0] exp;
        int f0, e0;
        for (int i = 0; i < COLORS; i++) qa.push_back(8'($urandom));
        for (int i = 0; i < COLORS; i++) qb.push_back(8'($urandom));
        f0 = frame_cnt; e0 = err_cnt;
        for (int i = 0; i < COLORS; i++) begin
            if (i == 1) begin
                send_level(1'b1, 3);
                send_level(1'b0, 15);
            end
            send_byte(qa[i], 2);
        end
        checks++; if (err_cnt - e0 !== 1) $display("FAIL glitch err pulses: got %0d expected 1", err_cnt - e0); else passes++;
        send_level(1'b0, 3979);              // 20 + 3979 = 3999 low clocks
        send_byte(8'h5A, 2);                 // continuation, forwarded not captured
        checks++; if (frame_cnt - f0 !== 0) $display("FAIL low 3999 latch: got %0d frames expected 0", frame_cnt - f0); else passes++;
        qa.push_back(8'h5A);
        model_frame(qa);
        send_level(1'b0, 3980);              // 20 + 3980 = 4000 low clocks
        send_frame(qb, 2);
        checks++; if (frame_cnt - f0 !== 1) $display("FAIL low 4000 latch: got %0d frames expected 1", frame_cnt - f0); else passes++;
        for (int a = 0; a < COLORS; a++) begin
            bus.i_addr = 3'(a);
            #1;
            exp = model_latched[a];
            checks++;
            if (bus.o_data !== exp) $display("FAIL boundary A data[%0d]: got %h expected %h", a, bus.o_data, exp);
            else passes++;
        end
        @(negedge clk);
        send_level(1'b0, 4010);
        model_frame(qb);
        checks++; if (frame_cnt - f0 !== 2 || err_cnt - e0 !== 1) $display("FAIL boundary pulses: got frame=%0d err=%0d expected 2/1", frame_cnt - f0, err_cnt - e0); else passes++;
        for (int a = 0; a < COLORS; a++) begin
            bus.i_addr = 3'(a);
            #1;
            exp = model_latched[a];
            checks++;
            if (bus.o_data !== exp) $display("FAIL boundary B data[%0d]: got %h expected %h", a, bus.o_data, exp);
            else passes++;
        end
        @(negedge clk);
    endtask

    task automatic test_short_frame();
        logic [7:0] q [$];
        logic [7:0] exp;
        int f0, e0;
        for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
        f0 = frame_cnt; e0 = err_cnt;
        send_frame(q, 1);
        send_level(1'b0, 4010);
        model_frame(q);
        checks++; if (err_cnt - e0 !== 1) $display("FAIL short err pulses: got %0d expected 1", err_cnt - e0); else passes++;
        checks++; if (frame_cnt - f0 !== 0) $display("FAIL short frame pulses: got %0d expected 0", frame_cnt - f0); else passes++;
        checks++; if (bus.o_valid !== model_valid) $display("FAIL short valid: got %b expected %b", bus.o_valid, model_valid); else passes++;
        for (int a = 0; a < COLORS; a++) begin
            bus.i_addr = 3'(a);
            #1;
            exp = model_latched[a];
            checks++;
            if (bus.o_data !== exp) $display("FAIL short data[%0d]: got %h expected %h", a, bus.o_data, exp);
            else passes++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        logic [7:0] q1 [$];
        logic [7:0] q2 [$];
        logic [7:0] exp;
        int f0, e0;
        for (int i = 0; i < COLORS; i++) q1.push_back(8'($urandom));
        for (int i = 0; i < COLORS; i++) q2.push_back(8'($urandom));
        send_byte(q1[0], 1);
        send_byte(q1[1], 1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < COLORS; i++) model_latched[i] = 8'h00;
        model_valid = 1'b0;
        checks++; if (bus.o_valid !== 1'b0) $display("FAIL midreset valid: got %b expected 0", bus.o_valid); else passes++;
        bus.i_addr = 3'd0;
        #1;
        checks++; if (bus.o_data !== 8'h00) $display("FAIL midreset data[0]: got %h expected 00", bus.o_data); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        f0 = frame_cnt; e0 = err_cnt;
        for (int i = 2; i < COLORS; i++) send_byte(q1[i], 1);
        send_level(1'b0, 4010);
        checks++; if (frame_cnt - f0 !== 0 || err_cnt - e0 !== 0) $display("FAIL midreset partial: got frame=%0d err=%0d expected 0/0", frame_cnt - f0, err_cnt - e0); else passes++;
        send_frame(q2, 1);
        send_level(1'b0, 4010);
        model_frame(q2);
        checks++; if (frame_cnt - f0 !== 1 || err_cnt - e0 !== 0) $display("FAIL midreset second: got frame=%0d err=%0d expected 1/0", frame_cnt - f0, err_cnt - e0); else passes++;
        checks++; if (bus.o_valid !== model_valid) $display("FAIL midreset valid after: got %b expected %b", bus.o_valid, model_valid); else passes++;
        for (int a = 0; a < COLORS; a++) begin
            bus.i_addr = 3'(a);
            #1;
            exp = model_latched[a];
            checks++;
            if (bus.o_data !== exp) $display("FAIL midreset data[%0d]: got %h expected %h", a, bus.o_data, exp);
            else passes++;
        end
        @(negedge clk);
    endtask

    task automatic test_overlong();
        logic [7:0] qp [$];
        logic [7:0] qf [$];
        logic [7:0] qg [$];
        logic [7:0] exp;
        int f0, e0;
        for (int i = 0; i < 3; i++) qp.push_back(8'($urandom));
        for (int i = 0; i < COLORS; i++) qf.push_back(8'($urandom));
        for (int i = 0; i < COLORS; i++) qg.push_back(8'($urandom));
        f0 = frame_cnt; e0 = err_cnt;
        send_frame(qp, 1);
        send_level(1'b1, 100);               // 2 us high
        send_level(1'b0, 20);
        checks++; if (err_cnt - e0 !== 1) $display("FAIL overlong err pulses: got %0d expected 1", err_cnt - e0); else passes++;
        send_frame(qf, 1);                   // arrives before an 80 us gap: ignored
        send_level(1'b0, 4010);
        checks++; if (frame_cnt - f0 !== 0 || err_cnt - e0 !== 1) $display("FAIL overlong ignore: got frame=%0d err=%0d expected 0/1", frame_cnt - f0, err_cnt - e0); else passes++;
        for (int a = 0; a < COLORS; a++) begin
            bus.i_addr = 3'(a);
            #1;
            exp = model_latched[a];
            checks++;
            if (bus.o_data !== exp) $display("FAIL overlong hold data[%0d]: got %h expected %h", a, bus.o_data, exp);
            else passes++;
        end
        @(negedge clk);
        send_frame(qg, 1);
        send_level(1'b0, 4010);
        model_frame(qg);
        checks++; if (frame_cnt - f0 !== 1) $display("FAIL overlong accept: got %0d frames expected 1", frame_cnt - f0); else passes++;
        for (int a = 0; a < COLORS; a++) begin
            bus.i_addr = 3'(a);
            #1;
            exp = model_latched[a];
            checks++;
            if (bus.o_data !== exp) $display("FAIL overlong data[%0d]: got %h expected %h", a, bus.o_data, exp);
            else passes++;
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < COLORS; i++) model_latched[i] = 8'h00;
        bus.i_addr = 3'd0;
        @(negedge clk);
        test_reset();
        test_fixed_frame();
        test_random_frames();
        test_passthrough();
        test_boundary();
        test_short_frame();
        test_reset_midframe();
        test_overlong();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
